// File: rtl/pipe_ctrl_sequencer.sv
// Pipeline control sequencer: load-use stall, branch squash, exception
// drain/redirect and halt handling for a classic five-stage pipeline.
module pipe_ctrl_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd_ind,
  input  logic [4:0]  rs1_ind,
  input  logic [4:0]  rs2_ind,
  input  logic        id_uses_rs2,
  input  logic        branch_taken,
  input  logic        exception_flag,
  input  logic        hlt,
  input  logic [31:0] id_pc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_flush,
  output logic        if_flush,
  output logic        exc_redirect,
  output logic [31:0] redirect_addr,
  output logic [31:0] epc,
  output logic        halted,
  output logic [7:0]  exc_lost
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    EXC_DRAIN    = 2'd1,
    EXC_REDIRECT = 2'd2,
    HALT         = 2'd3
  } state_e;

  // Counter load value: the drain runs from DRAIN_CYCLES-1 down to 0.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  exc_lost_q, exc_lost_d;
  logic        load_use;

  // Hazard: the load in EX writes a register the instruction in ID reads.
  assign load_use = id_ex_memread && (id_ex_rd_ind != 5'd0) &&
                    ((id_ex_rd_ind == rs1_ind) ||
                     (id_uses_rs2 && (id_ex_rd_ind == rs2_ind)));

  // State register plus drain counter, EPC and lost-exception counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 4'd0;
      epc_q      <= 32'd0;
      exc_lost_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      epc_q      <= epc_d;
      exc_lost_q <= exc_lost_d;
    end
  end

  // Next-state logic; exceptions only start a sequence from RUN.
  // NOTE: every always_comb output is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    epc_d      = epc_q;
    exc_lost_d = exc_lost_q;
    case (state_q)
      RUN: begin
        if (exception_flag) begin
          state_d = EXC_DRAIN;
          cnt_d   = DRAIN_LAST;
          epc_d   = id_pc;
        end else if (!load_use && hlt) begin
          state_d = HALT;
        end
      end
      EXC_DRAIN: begin
        if (cnt_q == 4'd0) state_d = EXC_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      EXC_REDIRECT: state_d = RUN;
      HALT:         state_d = HALT;
      default:      state_d = RUN;
    endcase
    if ((state_q != RUN) && exception_flag && (exc_lost_q != 8'hFF))
      exc_lost_d = exc_lost_q + 8'd1;
  end

  // Output decode: pipeline enables and flushes from state and RUN events.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_flush     = 1'b0;
    if_flush     = 1'b0;
    exc_redirect = 1'b0;
    halted       = 1'b0;
    case (state_q)
      RUN: begin
        if (exception_flag) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_flush    = 1'b1;
          if_flush    = 1'b1;
        end else if (load_use || hlt) begin
          // Load-use wins over a taken branch: the branch re-resolves next cycle.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_flush    = 1'b1;
        end else if (branch_taken) begin
          if_flush    = 1'b1;
        end
      end
      EXC_DRAIN: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_flush    = 1'b1;
        if_flush    = 1'b1;
      end
      EXC_REDIRECT: begin
        exc_redirect = 1'b1;
        id_flush     = 1'b1;
        if_flush     = 1'b1;
      end
      HALT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_flush    = 1'b1;
        if_flush    = 1'b1;
        halted      = 1'b1;
      end
      default: ;
    endcase
  end

  assign redirect_addr = EXC_VECTOR;
  assign epc           = epc_q;
  assign exc_lost      = exc_lost_q;

endmodule

// File: doc/pipe_ctrl_sequencer.md
PIPE_CTRL_SEQUENCER -- requirements
Module: pipe_ctrl_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, number of full-flush cycles before the exception redirect; legal range 1..15.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0100, handler address driven during redirect.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_ex_memread  input  1  the instruction in EX is a load.
REQ-006 id_ex_rd_ind  input  5  destination register of the instruction in EX.
REQ-007 rs1_ind, rs2_ind  input  5 each  source register indices of the instruction in ID.
REQ-008 id_uses_rs2  input  1  the instruction in ID reads rs2.
REQ-009 branch_taken  input  1  the ID comparator resolved a taken branch or jump.
REQ-010 exception_flag  input  1  the instruction in ID raised an exception.
REQ-011 hlt  input  1  the instruction in ID is a halt.
REQ-012 id_pc  input  32  PC of the instruction in ID.
REQ-013 pc_write, if_id_write  output  1 each  PC and IF/ID register write enables.
REQ-014 id_flush, if_flush  output  1 each  zero the ID control bits and squash IF/ID.
REQ-015 exc_redirect  output  1  select redirect_addr as the next PC.
REQ-016 redirect_addr  output  32  constant EXC_VECTOR.
REQ-017 epc  output  32  registered PC of the faulting instruction.
REQ-018 halted  output  1  core is halted.
REQ-019 exc_lost  output  8  saturating count of exceptions ignored outside RUN.

Function
REQ-020 The FSM SHALL have four states, RUN, EXC_DRAIN, EXC_REDIRECT and HALT, held in a registered state plus a 4-bit drain counter.
REQ-021 In RUN, the following SHALL be evaluated in this priority order: exception_flag, load-use, hlt, branch_taken.
REQ-022 Load-use SHALL be defined as id_ex_memread && id_ex_rd_ind!=0 && (id_ex_rd_ind==rs1_ind || (id_uses_rs2 && id_ex_rd_ind==rs2_ind)).
REQ-023 RUN, no event: pc_write=1, if_id_write=1, id_flush=0, if_flush=0, exc_redirect=0.
REQ-024 RUN with exception: same-cycle outputs pc_write=0, if_id_write=0, id_flush=1, if_flush=1. Next edge: epc<=id_pc, counter<=DRAIN_CYCLES-1, state<=EXC_DRAIN.
REQ-025 RUN with load-use and no exception: same-cycle outputs pc_write=0, if_id_write=0, id_flush=1, if_flush=0. The FSM SHALL remain in RUN; the stall lasts exactly one cycle per asserted condition.
REQ-026 RUN with hlt and no exception or load-use: same-cycle outputs as for load-use. Next edge: state<=HALT.
REQ-027 RUN with branch_taken only: pc_write=1, if_id_write=1, if_flush=1, id_flush=0.
REQ-028 If branch_taken and load-use are asserted together, load-use SHALL win and if_flush SHALL be 0.
REQ-029 EXC_DRAIN: outputs pc_write=0, if_id_write=0, id_flush=1, if_flush=1. The counter decrements each cycle; at counter==0 the next state SHALL be EXC_REDIRECT.
REQ-030 EXC_DRAIN SHALL therefore last exactly DRAIN_CYCLES cycles.
REQ-031 EXC_REDIRECT lasts one cycle with outputs pc_write=1, exc_redirect=1, if_flush=1, id_flush=1, if_id_write=1; next state SHALL be RUN.
REQ-032 HALT: outputs pc_write=0, if_id_write=0, id_flush=1, if_flush=1, halted=1. HALT SHALL be exited only by rst.
REQ-033 exception_flag in any state other than RUN SHALL NOT change state or epc; it SHALL increment exc_lost, saturating at 255.
REQ-034 epc SHALL be written only on the RUN-to-EXC_DRAIN transition.

Reset
REQ-035 rst SHALL immediately force: state=RUN, counter=0, epc=0, exc_lost=0, halted=0.
REQ-036 With all inputs 0 during reset, outputs SHALL read pc_write=1, if_id_write=1, id_flush=0, if_flush=0, exc_redirect=0.
REQ-037 rst asserted mid-drain or in HALT SHALL abort the sequence with no redirect pulse; the first cycle after deassertion SHALL be RUN.

Verification
REQ-038 Load-use: id_ex_memread=1, id_ex_rd_ind=5, rs1_ind=5 for one cycle -> pc_write=0, id_flush=1 that cycle only; state stays RUN. Repeating with rd=0 -> no stall.
REQ-039 Exception: id_pc=32'h40, exception_flag pulsed, DRAIN_CYCLES=3 -> 1 entry cycle + 3 drain cycles with pc_write=0, then one exc_redirect=1 cycle with redirect_addr=32'h100; epc=32'h40.
REQ-040 Simultaneous: exception_flag, load-use, hlt and branch_taken all asserted -> exception path taken; halted stays 0.
REQ-041 Lost exceptions: exception_flag held high for 300 cycles while in HALT -> exc_lost=255, state unchanged.
REQ-042 Reset mid-operation: rst asserted during the 2nd drain cycle -> outputs immediately at reset values, epc=0, and no exc_redirect pulse ever occurs.
REQ-043 Branch: branch_taken=1 alone -> if_flush=1, pc_write=1 for one cycle; branch_taken together with load-use -> if_flush=0.
